aemb2_intc: RTL

//  Interrupt controller upstream of the AEMB2 system-control stage; its int_o drives sys_int_i.

---
 rtl/aemb2_intc_pkg.sv | 27 ++
 rtl/aemb2_intc_if.sv | 21 ++
 rtl/aemb2_intc_src.sv | 60 ++++++
 rtl/aemb2_intc.sv | 94 +++++++++
 4 files changed

// File: rtl/aemb2_intc_pkg.sv
// Shared register map, constants and helpers for the AEMB2 interrupt controller.
package aemb2_intc_pkg;

    localparam int INTC_AW = 3;

    typedef enum logic [INTC_AW-1:0] {
        INTC_ISR = 3'd0,
        INTC_IPR = 3'd1,
        INTC_IER = 3'd2,
        INTC_IAR = 3'd3,
        INTC_SIE = 3'd4,
        INTC_CIE = 3'd5,
        INTC_IVR = 3'd6,
        INTC_MER = 3'd7
    } intc_reg_e;

    localparam logic [31:0] IVR_NONE = 32'hFFFF_FFFF;

    // Index of the lowest set bit; scanning downward lets the lowest index win.
    function automatic logic [31:0] lowest_set(input logic [31:0] v);
        lowest_set = IVR_NONE;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = 32'(i);
        end
    endfunction

endpackage

// File: rtl/aemb2_intc_if.sv
// Word-wide wishbone data-bus slave port of the interrupt controller.
interface aemb2_intc_if;

    logic                                dwb_stb_i;
    logic                                dwb_wre_i;
    logic [aemb2_intc_pkg::INTC_AW-1:0]  dwb_adr_i;
    logic [31:0]                         dwb_dat_i;
    logic [31:0]                         dwb_dat_o;
    logic                                dwb_ack_o;

    modport master (
        output dwb_stb_i, dwb_wre_i, dwb_adr_i, dwb_dat_i,
        input  dwb_dat_o, dwb_ack_o
    );

    modport slave (
        input  dwb_stb_i, dwb_wre_i, dwb_adr_i, dwb_dat_i,
        output dwb_dat_o, dwb_ack_o
    );

endinterface

// File: rtl/aemb2_intc_src.sv
// One interrupt source: optional synchroniser, edge/level detect and its pending bit.
module aemb2_intc_src #(
    parameter bit SYNC = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic edge_type,
    input  logic pol,
    input  logic ack_clr,
    output logic pend
);

    logic n, a, set;
    logic prev_q, prev_d;
    logic pend_q, pend_d;

    // Polarity is static, so normalising ahead of the synchroniser is equivalent
    // and lets every flop reset to the "deasserted" value 0.
    assign n = pol ? irq : ~irq;

    if (SYNC) begin : g_sync
        logic s1_q, s1_d, s2_q, s2_d;
        always_comb begin
            s1_d = n;
            s2_d = s1_q;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= s1_d;
                s2_q <= s2_d;
            end
        end
        assign a = s2_q;
    end else begin : g_direct
        assign a = n;
    end

    always_comb begin
        set    = a & (edge_type ? ~prev_q : 1'b1);
        prev_d = a;
        pend_d = (pend_q & ~ack_clr) | set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/aemb2_intc.sv
// AEMB2 interrupt controller: per-source pending logic, enables, priority vector and bus slave.
module aemb2_intc
    import aemb2_intc_pkg::*;
#(
    parameter int          NIRQ = 8,
    parameter logic [31:0] EDGE = 32'h0000_0000,
    parameter logic [31:0] POL  = 32'hFFFF_FFFF,
    parameter bit          SYNC = 1'b1
) (
    input  logic            sys_clk_i,
    input  logic            sys_rst_i,
    input  logic [NIRQ-1:0] irq_i,
    aemb2_intc_if.slave     dwb,
    output logic            int_o
);

    localparam logic [31:0] MASK = (NIRQ >= 32) ? 32'hFFFF_FFFF : ((32'h1 << NIRQ) - 32'h1);

    logic [NIRQ-1:0] pend;
    logic [31:0]     isr_w, ipr_w, wdat, iar_clr, rd_mux;
    logic [31:0]     ier_q, ier_d, dat_q, dat_d;
    logic            mer_q, mer_d, ack_q, ack_d, int_q, int_d;
    logic            acc, wr;
    intc_reg_e       reg_sel;

    for (genvar i = 0; i < NIRQ; i++) begin : g_src
        aemb2_intc_src #(.SYNC(SYNC)) u_src (
            .clk       (sys_clk_i),
            .rst       (sys_rst_i),
            .irq       (irq_i[i]),
            .edge_type (EDGE[i]),
            .pol       (POL[i]),
            .ack_clr   (iar_clr[i]),
            .pend      (pend[i])
        );
    end

    assign isr_w   = 32'(pend);
    assign ipr_w   = isr_w & ier_q;
    assign reg_sel = intc_reg_e'(dwb.dwb_adr_i);

    always_comb begin
        // Only the edge that raises ack performs the access, so a held strobe hits every other cycle.
        acc     = dwb.dwb_stb_i & ~ack_q;
        wr      = acc & dwb.dwb_wre_i;
        wdat    = dwb.dwb_dat_i & MASK;
        ack_d   = acc;
        ier_d   = ier_q;
        mer_d   = mer_q;
        iar_clr = '0;
        if (wr) begin
            case (reg_sel)
                INTC_IER: ier_d   = wdat;
                INTC_IAR: iar_clr = wdat;
                INTC_SIE: ier_d   = ier_q | wdat;
                INTC_CIE: ier_d   = ier_q & ~wdat;
                INTC_MER: mer_d   = dwb.dwb_dat_i[0];
                default:  ;
            endcase
        end
        rd_mux = '0;
        case (reg_sel)
            INTC_ISR: rd_mux = isr_w;
            INTC_IPR: rd_mux = ipr_w;
            INTC_IER: rd_mux = ier_q;
            INTC_IVR: rd_mux = lowest_set(ipr_w);
            INTC_MER: rd_mux = {31'b0, mer_q};
            default:  rd_mux = '0;
        endcase
        dat_d = (acc & ~dwb.dwb_wre_i) ? rd_mux : '0;
        int_d = mer_q & (|ipr_w);
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            ier_q <= '0;
            mer_q <= 1'b0;
            ack_q <= 1'b0;
            dat_q <= '0;
            int_q <= 1'b0;
        end else begin
            ier_q <= ier_d;
            mer_q <= mer_d;
            ack_q <= ack_d;
            dat_q <= dat_d;
            int_q <= int_d;
        end
    end

    assign dwb.dwb_ack_o = ack_q;
    assign dwb.dwb_dat_o = dat_q;
    assign int_o         = int_q;

endmodule
